// File: rtl/if_pc_unit.sv
// Fetch-stage PC register and F/D pipeline register with one-slot delayed branches/jumps.
// Illegal fetch targets freeze f_pc and raise a sticky addr_err.
module if_pc_unit #(
  parameter logic [31:0] PC_INIT = 32'h0000_3000,
  parameter logic [31:0] PC_MAX  = 32'h0000_6FFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] f_instr,
  input  logic [1:0]  npc_op,
  input  logic        compare_condition,
  input  logic [31:0] d_rs_data,
  output logic [31:0] f_pc,
  output logic [31:0] d_instr,
  output logic [31:0] d_pc,
  output logic [31:0] d_pc8,
  output logic        addr_err
);

  localparam logic [1:0] NPC_SEQ    = 2'd0;
  localparam logic [1:0] NPC_BRANCH = 2'd1;
  localparam logic [1:0] NPC_JUMP   = 2'd2;
  localparam logic [1:0] NPC_JR     = 2'd3;

  logic [31:0] seq_pc;
  logic [31:0] branch_off;
  logic [31:0] branch_pc;
  logic [31:0] jump_pc;
  logic [31:0] next_pc;
  logic        next_legal;

  assign seq_pc     = f_pc + 32'd4;
  assign branch_off = {{14{d_instr[15]}}, d_instr[15:0], 2'b00};
  // Branch target is relative to the delay-slot address (d_pc+4).
  assign branch_pc  = d_pc + 32'd4 + branch_off;
  assign jump_pc    = {d_pc[31:28], d_instr[25:0], 2'b00};
  assign d_pc8      = d_pc + 32'd8;

  always_comb begin
    next_pc = seq_pc;
    unique case (npc_op)
      NPC_SEQ:    next_pc = seq_pc;
      NPC_BRANCH: next_pc = compare_condition ? branch_pc : seq_pc;
      NPC_JUMP:   next_pc = jump_pc;
      NPC_JR:     next_pc = d_rs_data;
      default:    next_pc = seq_pc;
    endcase
  end

  assign next_legal = (next_pc[1:0] == 2'b00) && (next_pc >= PC_INIT) && (next_pc <= PC_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      f_pc     <= PC_INIT;
      d_instr  <= 32'h0;
      d_pc     <= 32'h0;
      addr_err <= 1'b0;
    end else if (!stall) begin
      d_instr <= f_instr;
      d_pc    <= f_pc;
      // Once in error, f_pc stays frozen until reset regardless of later targets.
      if (!addr_err) begin
        if (next_legal) begin
          f_pc <= next_pc;
        end else begin
          addr_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_if_pc_unit.sv
// Directed-vector bench for if_pc_unit with immediate-assertion checks.
module tb_if_pc_unit;

  logic        clk;
  logic        reset;
  logic        stall;
  logic [31:0] f_instr;
  logic [1:0]  npc_op;
  logic        compare_condition;
  logic [31:0] d_rs_data;
  logic [31:0] f_pc;
  logic [31:0] d_instr;
  logic [31:0] d_pc;
  logic [31:0] d_pc8;
  logic        addr_err;

  int n_cmp = 0;
  int n_err = 0;

  if_pc_unit dut (
    .clk(clk),
    .reset(reset),
    .stall(stall),
    .f_instr(f_instr),
    .npc_op(npc_op),
    .compare_condition(compare_condition),
    .d_rs_data(d_rs_data),
    .f_pc(f_pc),
    .d_instr(d_instr),
    .d_pc(d_pc),
    .d_pc8(d_pc8),
    .addr_err(addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; f_instr = 32'h0; npc_op = 2'd0;
    compare_condition = 1'b0; d_rs_data = 32'h0;
    #2;

    // Reset state
    do_reset();
    check("rst_f_pc", f_pc, 32'h3000);
    check("rst_d_instr", d_instr, 32'h0);
    check("rst_d_pc", d_pc, 32'h0);
    check("rst_d_pc8", d_pc8, 32'h8);
    check("rst_addr_err", {31'h0, addr_err}, 32'h0);

    // Sequential fetch
    f_instr = 32'hAAAA_0000; tick();
    check("seq1_f_pc", f_pc, 32'h3004);
    check("seq1_d_pc", d_pc, 32'h3000);
    check("seq1_d_instr", d_instr, 32'hAAAA_0000);
    f_instr = 32'hAAAA_0004; tick();
    check("seq2_f_pc", f_pc, 32'h3008);
    check("seq2_d_pc", d_pc, 32'h3004);
    f_instr = 32'hAAAA_0008; tick();
    check("seq3_f_pc", f_pc, 32'h300C);
    check("seq3_d_pc", d_pc, 32'h3008);
    check("seq3_addr_err", {31'h0, addr_err}, 32'h0);

    // Taken branch with negative offset from d_pc=3004
    do_reset();
    f_instr = 32'h1111_1111; tick();
    f_instr = 32'h1000_FFFE; tick();
    check("br_d_pc", d_pc, 32'h3004);
    check("br_d_pc8", d_pc8, 32'h300C);
    npc_op = 2'd1; compare_condition = 1'b1; f_instr = 32'hC0C0_3008; tick();
    check("br_f_pc", f_pc, 32'h3000);
    check("br_slot_d_pc", d_pc, 32'h3008);
    check("br_slot_d_instr", d_instr, 32'hC0C0_3008);

    // Stalled taken branch, positive offset: 3000+4+0x10
    npc_op = 2'd0; compare_condition = 1'b0; f_instr = 32'h1000_0004; tick();
    check("sb_pre_f_pc", f_pc, 32'h3004);
    check("sb_pre_d_pc", d_pc, 32'h3000);
    stall = 1'b1; npc_op = 2'd1; compare_condition = 1'b1; f_instr = 32'hEEEE_3004;
    tick();
    check("sb_st1_f_pc", f_pc, 32'h3004);
    check("sb_st1_d_pc", d_pc, 32'h3000);
    tick();
    check("sb_st2_f_pc", f_pc, 32'h3004);
    check("sb_st2_d_instr", d_instr, 32'h1000_0004);
    stall = 1'b0; tick();
    check("sb_go_f_pc", f_pc, 32'h3014);
    check("sb_go_d_pc", d_pc, 32'h3004);
    check("sb_go_d_instr", d_instr, 32'hEEEE_3004);

    // Not-taken branch falls through to f_pc+4
    compare_condition = 1'b0; f_instr = 32'h1000_0004; tick();
    check("bnt_f_pc", f_pc, 32'h3018);
    check("bnt_d_pc", d_pc, 32'h3014);

    // j from d_pc=3010
    do_reset();
    npc_op = 2'd0;
    for (int i = 0; i < 5; i++) begin
      f_instr = (i == 4) ? 32'h0800_0C40 : 32'h0;
      tick();
    end
    check("j_pre_d_pc", d_pc, 32'h3010);
    check("j_pre_d_pc8", d_pc8, 32'h3018);
    npc_op = 2'd2; f_instr = 32'h2222_2222; tick();
    check("j_f_pc", f_pc, 32'h3100);
    check("j_d_pc", d_pc, 32'h3014);

    // Misaligned jr sets addr_err, f_pc freezes, F/D keeps loading
    npc_op = 2'd3; d_rs_data = 32'h0000_3002; f_instr = 32'h3333_3333; tick();
    check("jr_bad_err", {31'h0, addr_err}, 32'h1);
    check("jr_bad_f_pc", f_pc, 32'h3100);
    check("jr_bad_d_pc", d_pc, 32'h3100);
    d_rs_data = 32'h0000_3040; f_instr = 32'h4444_4444; tick();
    check("jr_frozen_f_pc", f_pc, 32'h3100);
    check("jr_frozen_err", {31'h0, addr_err}, 32'h1);
    check("jr_frozen_d_instr", d_instr, 32'h4444_4444);

    // Reset dominates stall and a pending jump
    stall = 1'b1; npc_op = 2'd2; reset = 1'b1; tick();
    check("rdom_f_pc", f_pc, 32'h3000);
    check("rdom_d_instr", d_instr, 32'h0);
    check("rdom_d_pc", d_pc, 32'h0);
    check("rdom_err", {31'h0, addr_err}, 32'h0);
    reset = 1'b0; stall = 1'b0; npc_op = 2'd0; f_instr = 32'h0; tick();
    check("rdom_next_f_pc", f_pc, 32'h3004);

    // Target just below PC_INIT is illegal
    npc_op = 2'd3; d_rs_data = 32'h0000_2FFC; tick();
    check("lo_err", {31'h0, addr_err}, 32'h1);
    check("lo_f_pc", f_pc, 32'h3004);

    // PC_MAX itself is legal; sequential fetch past it is not
    do_reset();
    d_rs_data = 32'h0000_6FFC; tick();
    check("max_f_pc", f_pc, 32'h6FFC);
    check("max_err", {31'h0, addr_err}, 32'h0);
    npc_op = 2'd0; tick();
    check("past_err", {31'h0, addr_err}, 32'h1);
    check("past_f_pc", f_pc, 32'h6FFC);
    check("past_d_pc", d_pc, 32'h6FFC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
